sim_ctrl_monitor: RTL and testbench
===================================

# sim_ctrl_monitor

Synthesizable simulation-control monitor that snoops the tiny-SoC SRAM request bus for writes to magic addresses and turns them into run/drain/done control, per-channel logging windows and a stop cause. It sits beside the SoC memory port, so benches and emulation targets share one stop/log protocol. It extends the single-stop, single-log scheme to N log channels, a cycle limit, a bus-idle watchdog and an exit code.

## Interface

Parameters:
- ADDR_WIDTH, 21: SRAM word address width.
- DATA_WIDTH, 128: SRAM data width.
- NUM_LOG_CH, 4: number of independent log windows (1..16).
- STOP_ADDR, 0: stop-request address.
- LOG_START_BASE, 8: start address of channel 0.
- LOG_STOP_BASE, 16: stop address of channel 0.
- LOG_STRIDE, 16: address step between channels.
- DRAIN_CYCLES, 50: extra cycles run after a stop request.
- TIMEOUT_LIM, 1000: consecutive idle-bus cycles before watchdog stop; 0 disables it.
- CNT_WIDTH, 32: width of all counters.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req_i  in  1  SRAM request valid.
- mem_we_i  in  1  write enable.
- mem_addr_i  in  ADDR_WIDTH  request address.
- mem_wdata_i  in  DATA_WIDTH  write data.
- simlen_i  in  CNT_WIDTH  cycle limit; 0 = unlimited; sampled every cycle.
- log_en_o  out  NUM_LOG_CH  per-channel logging window active.
- log_cnt_o  out  NUM_LOG_CH*CNT_WIDTH  per-channel count of log_en cycles; channel k sits at [k*CNT_WIDTH +: CNT_WIDTH].
- draining_o  out  1  state is DRAIN.
- done_o  out  1  state is DONE; sticky.
- stop_cause_o  out  2  0 none, 1 stop request, 2 simlen, 3 watchdog.
- exit_code_o  out  8  mem_wdata_i[7:0] captured on the stop write.
- cycle_cnt_o  out  CNT_WIDTH  cycles spent in RUN and DRAIN.

## Operation

- Snoop write: mem_req_i && mem_we_i. The strobe is ignored and the address compare is exact.
- Channel k uses start address LOG_START_BASE + k*LOG_STRIDE and stop address LOG_STOP_BASE + k*LOG_STRIDE.
- FSM states: RUN, DRAIN, DONE. Reset enters RUN.
- RUN, priority from highest to lowest:
  - simlen_i != 0 and cycle_cnt == simlen_i-1: go to DONE, cause 2.
  - Watchdog reaches TIMEOUT_LIM: go to DONE, cause 3.
  - Snoop write to STOP_ADDR: go to DRAIN, cause 1, capture exit_code, load drain_cnt = DRAIN_CYCLES, clear all log_en.
  - Otherwise: a start write sets log_en[k] and a stop write clears log_en[k]. A start write on an already-set channel has no effect.
- DRAIN:
  - Log writes and stop writes are ignored.
  - drain_cnt == 0: go to DONE (cause stays 1); otherwise drain_cnt--.
  - The simlen check still applies and overrides the cause to 2 when it fires.
  - The watchdog is inactive.
- DONE: absorbing until rst. All counters freeze and log_en stays 0.
- Watchdog counter:
  - Counts consecutive RUN cycles with mem_req_i low.
  - Cleared by any mem_req_i and on leaving RUN.
  - Saturates at TIMEOUT_LIM.
- cycle_cnt increments in RUN and DRAIN and saturates at all-ones. log_cnt[k] increments each cycle log_en[k] is 1 and saturates.
- Reset values: every output 0, drain_cnt 0, watchdog 0.

## Timing

- All outputs are registered. A snoop write sampled at edge e takes effect on the outputs after e, i.e. visible in cycle e+1.
- Stop write at edge e0: draining_o is high from e0 through e0+DRAIN_CYCLES, and done_o rises after edge e0+DRAIN_CYCLES+1. With the defaults, done_o rises 51 cycles after the stop write.
- simlen_i = L: done_o rises after edge L-1 counted from the first edge after reset is released, and cycle_cnt_o freezes at L-1.
- Same-edge collisions:
  - simlen beats watchdog, and watchdog beats stop request.
  - A stop write beats a log write; only one address can be presented per cycle.
- rst asserted mid-DRAIN or in DONE: the next cycle is RUN with all state cleared, including the exit code and cause.

## Test plan

- Channel 0 window: write 8, 5 idle requests, write 16 → log_en_o[0] high for 6 cycles, log_cnt ch0 = 6, other channels 0.
- Channels 1 and 3 overlapping: write 24, write 56, write 32, write 64 → windows are independent and each count matches its window length.
- Stop write at addr 0 with wdata 0x2A, DRAIN_CYCLES = 50 → draining_o lasts 51 cycles, then done_o = 1, cause 1, exit_code 0x2A, log_en all 0, and a write to 8 during DRAIN is ignored.
- simlen_i = 100 with no stop write → done_o after cycle 99, cause 2, cycle_cnt_o = 99. Repeat with a stop write at cycle 99 → cause 2.
- TIMEOUT_LIM = 1000 with no mem_req after reset → done_o after 1000 idle cycles, cause 3. A single mem_req at idle cycle 999 restarts the count.
- rst pulse during DRAIN → all outputs 0 next cycle, FSM back in RUN and logging works again.

Source files
------------

// File: rtl/sim_ctrl_monitor.sv
// Simulation-control monitor: snoops SRAM writes to magic addresses and drives
// run/drain/done state, per-channel log windows, stop cause and exit code.
module sim_ctrl_monitor #(
  parameter int ADDR_WIDTH     = 21,
  parameter int DATA_WIDTH     = 128,
  parameter int NUM_LOG_CH     = 4,
  parameter int STOP_ADDR      = 0,
  parameter int LOG_START_BASE = 8,
  parameter int LOG_STOP_BASE  = 16,
  parameter int LOG_STRIDE     = 16,
  parameter int DRAIN_CYCLES   = 50,
  parameter int TIMEOUT_LIM    = 1000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mem_req_i,
  input  logic                             mem_we_i,
  input  logic [ADDR_WIDTH-1:0]            mem_addr_i,
  input  logic [DATA_WIDTH-1:0]            mem_wdata_i,
  input  logic [CNT_WIDTH-1:0]             simlen_i,
  output logic [NUM_LOG_CH-1:0]            log_en_o,
  output logic [NUM_LOG_CH*CNT_WIDTH-1:0]  log_cnt_o,
  output logic                             draining_o,
  output logic                             done_o,
  output logic [1:0]                       stop_cause_o,
  output logic [7:0]                       exit_code_o,
  output logic [CNT_WIDTH-1:0]             cycle_cnt_o
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] STOP_A  = ADDR_WIDTH'(STOP_ADDR);
  localparam logic [CNT_WIDTH-1:0]  DRAIN_C = CNT_WIDTH'(DRAIN_CYCLES);
  localparam logic [CNT_WIDTH-1:0]  WD_LIM  = CNT_WIDTH'(TIMEOUT_LIM);

  state_t                          state_q, state_d;
  logic [CNT_WIDTH-1:0]            cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0]            drain_cnt_q, drain_cnt_d;
  logic [CNT_WIDTH-1:0]            wd_cnt_q, wd_cnt_d;
  logic [NUM_LOG_CH-1:0]           log_en_q, log_en_d;
  logic [NUM_LOG_CH*CNT_WIDTH-1:0] log_cnt_q, log_cnt_d;
  logic [1:0]                      cause_q, cause_d;
  logic [7:0]                      exit_q, exit_d;
  logic                            draining_q, done_q;

  logic snoop_wr, simlen_hit, wd_hit;
  logic unused_wdata;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] ch_addr(input int base, input int k);
    return ADDR_WIDTH'(base + k * LOG_STRIDE);
  endfunction

  assign unused_wdata = ^mem_wdata_i[DATA_WIDTH-1:8];
  assign snoop_wr     = mem_req_i && mem_we_i;
  assign simlen_hit   = (simlen_i != '0) && (cycle_cnt_q == simlen_i - 1'b1);
  // Fires on the idle cycle that would bring the watchdog up to its limit.
  assign wd_hit       = (WD_LIM != '0) && !mem_req_i && (wd_cnt_q == WD_LIM - 1'b1);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    wd_cnt_d    = '0;
    log_en_d    = log_en_q;
    cause_d     = cause_q;
    exit_d      = exit_q;
    log_cnt_d   = log_cnt_q;

    for (int k = 0; k < NUM_LOG_CH; k++) begin
      if (log_en_q[k])
        log_cnt_d[k*CNT_WIDTH +: CNT_WIDTH] = sat_inc(log_cnt_q[k*CNT_WIDTH +: CNT_WIDTH]);
    end

    case (state_q)
      S_RUN: begin
        if (mem_req_i)
          wd_cnt_d = '0;
        else if (wd_cnt_q == WD_LIM)
          wd_cnt_d = wd_cnt_q;
        else
          wd_cnt_d = wd_cnt_q + 1'b1;

        if (simlen_hit) begin
          state_d  = S_DONE;
          cause_d  = 2'd2;
          log_en_d = '0;
          wd_cnt_d = '0;
        end else if (wd_hit) begin
          state_d  = S_DONE;
          cause_d  = 2'd3;
          log_en_d = '0;
          wd_cnt_d = '0;
        end else if (snoop_wr && mem_addr_i == STOP_A) begin
          state_d     = S_DRAIN;
          cause_d     = 2'd1;
          exit_d      = mem_wdata_i[7:0];
          drain_cnt_d = DRAIN_C;
          log_en_d    = '0;
          wd_cnt_d    = '0;
        end else if (snoop_wr) begin
          for (int k = 0; k < NUM_LOG_CH; k++) begin
            if (mem_addr_i == ch_addr(LOG_START_BASE, k))
              log_en_d[k] = 1'b1;
            else if (mem_addr_i == ch_addr(LOG_STOP_BASE, k))
              log_en_d[k] = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (simlen_hit) begin
          state_d = S_DONE;
          cause_d = 2'd2;
        end else if (drain_cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      S_DONE: ;
      default: state_d = S_RUN;
    endcase

    // The edge that enters DONE is not counted, so simlen L freezes at L-1.
    cycle_cnt_d = (state_q != S_DONE && state_d != S_DONE) ? sat_inc(cycle_cnt_q) : cycle_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      cycle_cnt_q <= '0;
      drain_cnt_q <= '0;
      wd_cnt_q    <= '0;
      log_en_q    <= '0;
      log_cnt_q   <= '0;
      cause_q     <= '0;
      exit_q      <= '0;
      draining_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      log_en_q    <= log_en_d;
      log_cnt_q   <= log_cnt_d;
      cause_q     <= cause_d;
      exit_q      <= exit_d;
      draining_q  <= (state_d == S_DRAIN);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign log_en_o     = log_en_q;
  assign log_cnt_o    = log_cnt_q;
  assign draining_o   = draining_q;
  assign done_o       = done_q;
  assign stop_cause_o = cause_q;
  assign exit_code_o  = exit_q;
  assign cycle_cnt_o  = cycle_cnt_q;

endmodule

// File: tb/tb_sim_ctrl_monitor.sv
// Directed bench for sim_ctrl_monitor with default parameters.
module tb_sim_ctrl_monitor;
  localparam int AW = 21;
  localparam int DW = 128;
  localparam int NC = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req_i, mem_we_i;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_wdata_i;
  logic [CW-1:0] simlen_i;
  logic [NC-1:0] log_en_o;
  logic [NC*CW-1:0] log_cnt_o;
  logic          draining_o, done_o;
  logic [1:0]    stop_cause_o;
  logic [7:0]    exit_code_o;
  logic [CW-1:0] cycle_cnt_o;

  int total = 0;
  int bad   = 0;

  sim_ctrl_monitor dut (
    .clk(clk), .rst(rst), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .simlen_i(simlen_i),
    .log_en_o(log_en_o), .log_cnt_o(log_cnt_o), .draining_o(draining_o),
    .done_o(done_o), .stop_cause_o(stop_cause_o), .exit_code_o(exit_code_o),
    .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wr(input int addr, input int data);
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = AW'(addr); mem_wdata_i = DW'(data);
    tick();
    mem_req_i = 1'b0; mem_we_i = 1'b0;
  endtask

  task automatic rd();
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = AW'(100);
    tick();
    mem_req_i = 1'b0;
  endtask

  function automatic logic [CW-1:0] lc(input int k);
    return log_cnt_o[k*CW +: CW];
  endfunction

  task automatic test_reset();
    simlen_i = '0;
    do_reset();
    total++; if (log_en_o !== 4'h0) begin bad++; $display("FAIL reset_log_en got=%0h exp=0", log_en_o); end
    total++; if (log_cnt_o !== '0) begin bad++; $display("FAIL reset_log_cnt got=%0h exp=0", log_cnt_o); end
    total++; if ({draining_o, done_o, stop_cause_o} !== 4'h0) begin bad++; $display("FAIL reset_ctrl got=%0h exp=0", {draining_o, done_o, stop_cause_o}); end
    total++; if (exit_code_o !== 8'h0) begin bad++; $display("FAIL reset_exit got=%0h exp=0", exit_code_o); end
    total++; if (cycle_cnt_o !== '0) begin bad++; $display("FAIL reset_cycle got=%0d exp=0", cycle_cnt_o); end
  endtask

  task automatic test_ch0_window();
    int high = 0;
    do_reset();
    wr(8, 0);
    if (log_en_o[0]) high++;
    total++; if (log_en_o !== 4'b0001) begin bad++; $display("FAIL ch0_open got=%0h exp=1", log_en_o); end
    for (int i = 0; i < 5; i++) begin
      rd();
      if (log_en_o[0]) high++;
    end
    wr(16, 0);
    if (log_en_o[0]) high++;
    total++; if (log_en_o !== 4'b0000) begin bad++; $display("FAIL ch0_close got=%0h exp=0", log_en_o); end
    total++; if (high !== 6) begin bad++; $display("FAIL ch0_high_cycles got=%0d exp=6", high); end
    rd();
    total++; if (lc(0) !== 32'd6) begin bad++; $display("FAIL ch0_cnt got=%0d exp=6", lc(0)); end
    total++; if ({lc(1), lc(2), lc(3)} !== '0) begin bad++; $display("FAIL ch0_others got=%0h exp=0", {lc(1), lc(2), lc(3)}); end
  endtask

  task automatic test_overlap();
    do_reset();
    wr(24, 0); rd(); wr(56, 0);
    total++; if (log_en_o !== 4'b1010) begin bad++; $display("FAIL ovl_both got=%0h exp=a", log_en_o); end
    rd(); rd(); rd(); wr(32, 0);
    total++; if (log_en_o !== 4'b1000) begin bad++; $display("FAIL ovl_ch3_only got=%0h exp=8", log_en_o); end
    rd(); rd(); wr(64, 0); rd();
    total++; if (log_en_o !== 4'b0000) begin bad++; $display("FAIL ovl_closed got=%0h exp=0", log_en_o); end
    total++; if (lc(1) !== 32'd6) begin bad++; $display("FAIL ovl_ch1_cnt got=%0d exp=6", lc(1)); end
    total++; if (lc(3) !== 32'd7) begin bad++; $display("FAIL ovl_ch3_cnt got=%0d exp=7", lc(3)); end
    total++; if ({lc(0), lc(2)} !== '0) begin bad++; $display("FAIL ovl_ch02_cnt got=%0h exp=0", {lc(0), lc(2)}); end
  endtask

  task automatic test_stop_drain();
    int dr = 0;
    int n = 0;
    logic [CW-1:0] cyc;
    do_reset();
    wr(8, 0);
    wr(0, 32'h2A);
    if (draining_o) dr++;
    total++; if ({draining_o, done_o, stop_cause_o} !== 4'b1001) begin bad++; $display("FAIL stop_enter got=%0h exp=9", {draining_o, done_o, stop_cause_o}); end
    total++; if (log_en_o !== 4'h0) begin bad++; $display("FAIL stop_log_clear got=%0h exp=0", log_en_o); end
    while (!done_o && n < 100) begin
      if (n == 0) wr(8, 0); else rd();
      if (n == 0) begin
        total++; if (log_en_o !== 4'h0) begin bad++; $display("FAIL drain_log_ignored got=%0h exp=0", log_en_o); end
      end
      if (draining_o) dr++;
      n++;
    end
    total++; if (dr !== 51) begin bad++; $display("FAIL drain_len got=%0d exp=51", dr); end
    total++; if ({draining_o, done_o, stop_cause_o} !== 4'b0101) begin bad++; $display("FAIL drain_done got=%0h exp=5", {draining_o, done_o, stop_cause_o}); end
    total++; if (exit_code_o !== 8'h2A) begin bad++; $display("FAIL drain_exit got=%0h exp=2a", exit_code_o); end
    total++; if (lc(0) !== 32'd1) begin bad++; $display("FAIL drain_ch0_cnt got=%0d exp=1", lc(0)); end
    total++; if (cycle_cnt_o !== 32'd52) begin bad++; $display("FAIL drain_cycle got=%0d exp=52", cycle_cnt_o); end
    cyc = cycle_cnt_o;
    wr(8, 0); rd(); rd();
    total++; if ({done_o, log_en_o} !== 5'b10000) begin bad++; $display("FAIL done_sticky got=%0h exp=10", {done_o, log_en_o}); end
    total++; if (cycle_cnt_o !== 32'd52 || cyc !== 32'd52) begin bad++; $display("FAIL done_freeze got=%0d exp=52", cycle_cnt_o); end
  endtask

  task automatic test_simlen();
    int n = 0;
    simlen_i = 32'd100;
    do_reset();
    while (!done_o && n < 200) begin rd(); n++; end
    total++; if (n !== 100) begin bad++; $display("FAIL simlen_edges got=%0d exp=100", n); end
    total++; if (stop_cause_o !== 2'd2) begin bad++; $display("FAIL simlen_cause got=%0d exp=2", stop_cause_o); end
    total++; if (cycle_cnt_o !== 32'd99) begin bad++; $display("FAIL simlen_cycle got=%0d exp=99", cycle_cnt_o); end
    do_reset();
    for (int i = 0; i < 99; i++) rd();
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL simlen_early got=%0b exp=0", done_o); end
    wr(0, 32'h55);
    total++; if ({draining_o, done_o, stop_cause_o} !== 4'b0110) begin bad++; $display("FAIL simlen_vs_stop got=%0h exp=6", {draining_o, done_o, stop_cause_o}); end
    total++; if (exit_code_o !== 8'h00) begin bad++; $display("FAIL simlen_vs_stop_exit got=%0h exp=0", exit_code_o); end
    simlen_i = '0;
  endtask

  task automatic test_watchdog();
    int n = 0;
    simlen_i = '0;
    do_reset();
    while (!done_o && n < 1100) begin tick(); n++; end
    total++; if (n !== 1000) begin bad++; $display("FAIL wd_edges got=%0d exp=1000", n); end
    total++; if (stop_cause_o !== 2'd3) begin bad++; $display("FAIL wd_cause got=%0d exp=3", stop_cause_o); end
    do_reset();
    for (int i = 0; i < 999; i++) tick();
    rd();
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL wd_restart got=%0b exp=0", done_o); end
    n = 0;
    while (!done_o && n < 1100) begin tick(); n++; end
    total++; if (n !== 1000 || stop_cause_o !== 2'd3) begin bad++; $display("FAIL wd_recount got=%0d/%0d exp=1000/3", n, stop_cause_o); end
  endtask

  task automatic test_simlen_vs_wd();
    int n = 0;
    simlen_i = 32'd1000;
    do_reset();
    while (!done_o && n < 1100) begin tick(); n++; end
    total++; if (n !== 1000 || stop_cause_o !== 2'd2) begin bad++; $display("FAIL simlen_vs_wd got=%0d/%0d exp=1000/2", n, stop_cause_o); end
    simlen_i = '0;
  endtask

  task automatic test_rst_drain();
    do_reset();
    wr(0, 32'h77);
    rd(); rd();
    total++; if (draining_o !== 1'b1) begin bad++; $display("FAIL rstd_draining got=%0b exp=1", draining_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({draining_o, done_o, stop_cause_o, exit_code_o} !== 12'h0) begin bad++; $display("FAIL rstd_clear got=%0h exp=0", {draining_o, done_o, stop_cause_o, exit_code_o}); end
    total++; if (cycle_cnt_o !== '0) begin bad++; $display("FAIL rstd_cycle got=%0d exp=0", cycle_cnt_o); end
    wr(40, 0);
    total++; if (log_en_o !== 4'b0100) begin bad++; $display("FAIL rstd_log_open got=%0h exp=4", log_en_o); end
    wr(48, 0);
    total++; if (log_en_o !== 4'b0000 || lc(2) !== 32'd1) begin bad++; $display("FAIL rstd_log_close got=%0h/%0d exp=0/1", log_en_o, lc(2)); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; simlen_i = '0;
    test_reset();
    test_ch0_window();
    test_overlap();
    test_stop_drain();
    test_simlen();
    test_watchdog();
    test_simlen_vs_wd();
    test_rst_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
